// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu constants: memory op encodings, ROB tag width, LSB FSM states
package cpu_pkg;

  localparam int ROB_W_DEF = 4;

  // bit3 = store, [2:0] = access width and signedness
  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic {
    LSB_IDLE = 1'b0,
    LSB_BUSY = 1'b1
  } lsb_state_e;

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/lsb_wakeup.sv
// rtl/lsb_wakeup.sv - operand wakeup for one buffer entry: matches pending tags against the CDB ports
module lsb_wakeup
  import cpu_pkg::*;
#(
  parameter int NCDB  = 2,
  parameter int ROB_W = ROB_W_DEF
) (
  input  logic                  dj,
  input  logic                  dk,
  input  logic [ROB_W-1:0]      qj,
  input  logic [ROB_W-1:0]      qk,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NCDB*32-1:0]    cdb_value,
  output logic                  hit_j,
  output logic                  hit_k,
  output logic [31:0]           val_j,
  output logic [31:0]           val_k
);

  // Scan from the highest port down so the lowest matching port is the last writer.
  always_comb begin
    hit_j = 1'b0;
    hit_k = 1'b0;
    val_j = '0;
    val_k = '0;
    for (int p = NCDB - 1; p >= 0; p--) begin
      if (cdb_valid[p] && dj && (cdb_rob_id[p*ROB_W +: ROB_W] == qj)) begin
        hit_j = 1'b1;
        val_j = cdb_value[p*32 +: 32];
      end
      if (cdb_valid[p] && dk && (cdb_rob_id[p*ROB_W +: ROB_W] == qk)) begin
        hit_k = 1'b1;
        val_k = cdb_value[p*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/lsb_param.sv
// rtl/lsb_param.sv - in-order load/store buffer with CDB snooping, commit-gated stores and flush
module lsb_param
  import cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ROB_W = ROB_W_DEF,
  parameter int NCDB  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  issue_valid,
  input  logic [3:0]            issue_op,
  input  logic [31:0]           issue_vj,
  input  logic [31:0]           issue_vk,
  input  logic [31:0]           issue_imm,
  input  logic                  issue_dj,
  input  logic                  issue_dk,
  input  logic [ROB_W-1:0]      issue_qj,
  input  logic [ROB_W-1:0]      issue_qk,
  input  logic [ROB_W-1:0]      issue_rob_id,
  output logic                  full,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NCDB*32-1:0]    cdb_value,
  input  logic                  commit_store,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_op,
  input  logic                  mem_done,
  input  logic [31:0]           mem_rdata,
  output logic                  out_valid,
  output logic [ROB_W-1:0]      out_rob_id,
  output logic [31:0]           out_value
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, comm_q, comm_d, dj_q, dj_d, dk_q, dk_d;
  lsb_state_e       state_q, state_d;

  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_op_q, mem_op_d;
  logic             out_valid_q, out_valid_d;
  logic [ROB_W-1:0] out_rob_id_q, out_rob_id_d;
  logic [31:0]      out_value_q, out_value_d;
  logic [ROB_W-1:0] fl_rob_q, fl_rob_d;
  logic             fl_load_q, fl_load_d;
  logic             drop_q, drop_d;

  logic [3:0]       op_q  [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];

  logic [DEPTH-1:0] hit_j, hit_k;
  logic [31:0]      wval_j [DEPTH];
  logic [31:0]      wval_k [DEPTH];
  logic             iss_hit_j, iss_hit_k;
  logic [31:0]      iss_val_j, iss_val_k;

  logic             do_issue, head_store, head_elig, pop;
  logic [DEPTH-1:0] keep;
  logic [CW-1:0]    ret;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    lsb_wakeup #(.NCDB(NCDB), .ROB_W(ROB_W)) u_wake (
      .dj         (busy_q[g] && dj_q[g]),
      .dk         (busy_q[g] && dk_q[g]),
      .qj         (qj_q[g]),
      .qk         (qk_q[g]),
      .cdb_valid  (cdb_valid),
      .cdb_rob_id (cdb_rob_id),
      .cdb_value  (cdb_value),
      .hit_j      (hit_j[g]),
      .hit_k      (hit_k[g]),
      .val_j      (wval_j[g]),
      .val_k      (wval_k[g])
    );
  end

  // Bypass instance: the issuing entry sees the same-cycle broadcast.
  lsb_wakeup #(.NCDB(NCDB), .ROB_W(ROB_W)) u_wake_iss (
    .dj         (issue_dj),
    .dk         (issue_dk),
    .qj         (issue_qj),
    .qk         (issue_qk),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .hit_j      (iss_hit_j),
    .hit_k      (iss_hit_k),
    .val_j      (iss_val_j),
    .val_k      (iss_val_k)
  );

  assign full       = (count_q == CW'(DEPTH));
  assign do_issue   = issue_valid && !full && !clear;
  assign head_store = op_is_store(op_q[head_q]);
  assign head_elig  = busy_q[head_q] && !dj_q[head_q] &&
                      (!head_store || (!dk_q[head_q] && comm_q[head_q]));
  assign pop        = (state_q == LSB_BUSY) && mem_done && !drop_q;

  // Committed stores form a contiguous run from head; that run survives a flush.
  always_comb begin
    logic          run;
    logic [AW-1:0] idx;
    keep = '0;
    ret  = '0;
    run  = 1'b1;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (run && busy_q[idx] && comm_q[idx]) begin
        keep[idx] = 1'b1;
        ret       = ret + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_op_d     = mem_op_q;
    out_valid_d  = 1'b0;
    out_rob_id_d = out_rob_id_q;
    out_value_d  = out_value_q;
    fl_rob_d     = fl_rob_q;
    fl_load_d    = fl_load_q;
    drop_d       = drop_q;

    case (state_q)
      LSB_IDLE: begin
        if (head_elig && !clear) begin
          state_d     = LSB_BUSY;
          mem_req_d   = 1'b1;
          mem_addr_d  = vj_q[head_q] + imm_q[head_q];
          mem_wdata_d = head_store ? vk_q[head_q] : 32'h0;
          mem_op_d    = op_q[head_q];
          fl_rob_d    = rob_q[head_q];
          fl_load_d   = !head_store;
        end
      end
      LSB_BUSY: begin
        if (mem_done) begin
          state_d   = LSB_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!drop_q && !(clear && fl_load_q)) begin
            out_valid_d  = 1'b1;
            out_rob_id_d = fl_rob_q;
            out_value_d  = fl_load_q ? mem_rdata : 32'h0;
          end
        end else if (clear && fl_load_q) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = LSB_IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    comm_d  = comm_q;
    dj_d    = dj_q & ~hit_j;
    dk_d    = dk_q & ~hit_k;

    if (clear) begin
      busy_d = keep;
      comm_d = comm_q & keep;
      dj_d   = dj_d & keep;
      dk_d   = dk_d & keep;
      tail_d = head_q + AW'(ret);
      if (pop && !fl_load_q) begin
        busy_d[head_q] = 1'b0;
        comm_d[head_q] = 1'b0;
        head_d         = head_q + AW'(1);
        count_d        = ret - CW'(1);
      end else begin
        count_d = ret;
      end
    end else begin
      if (commit_store && busy_q[head_q] && head_store) comm_d[head_q] = 1'b1;
      if (pop) begin
        busy_d[head_q] = 1'b0;
        comm_d[head_q] = 1'b0;
        head_d         = head_q + AW'(1);
      end
      if (do_issue) begin
        busy_d[tail_q] = 1'b1;
        comm_d[tail_q] = 1'b0;
        dj_d[tail_q]   = issue_dj && !iss_hit_j;
        dk_d[tail_q]   = issue_dk && !iss_hit_k;
        tail_d         = tail_q + AW'(1);
      end
      count_d = count_q + CW'(do_issue) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      comm_q       <= '0;
      dj_q         <= '0;
      dk_q         <= '0;
      state_q      <= LSB_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_op_q     <= '0;
      out_valid_q  <= 1'b0;
      out_rob_id_q <= '0;
      out_value_q  <= '0;
      fl_rob_q     <= '0;
      fl_load_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else if (rdy_in) begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      comm_q       <= comm_d;
      dj_q         <= dj_d;
      dk_q         <= dk_d;
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_op_q     <= mem_op_d;
      out_valid_q  <= out_valid_d;
      out_rob_id_q <= out_rob_id_d;
      out_value_q  <= out_value_d;
      fl_rob_q     <= fl_rob_d;
      fl_load_q    <= fl_load_d;
      drop_q       <= drop_d;
    end
  end

  // Payload storage is qualified by the busy flags, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_issue && (tail_q == AW'(i))) begin
          op_q[i]  <= issue_op;
          vj_q[i]  <= iss_hit_j ? iss_val_j : issue_vj;
          vk_q[i]  <= iss_hit_k ? iss_val_k : issue_vk;
          imm_q[i] <= issue_imm;
          qj_q[i]  <= issue_qj;
          qk_q[i]  <= issue_qk;
          rob_q[i] <= issue_rob_id;
        end else begin
          if (hit_j[i]) vj_q[i] <= wval_j[i];
          if (hit_k[i]) vk_q[i] <= wval_k[i];
        end
      end
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_op     = mem_op_q;
  assign out_valid  = out_valid_q;
  assign out_rob_id = out_rob_id_q;
  assign out_value  = out_value_q;

endmodule

// File: tb/tb_lsb_param.sv
// tb/tb_lsb_param.sv - directed vector bench for lsb_param
module tb_lsb_param;
  import cpu_pkg::*;

  localparam int DEPTH = 16;
  localparam int ROB_W = 4;
  localparam int NCDB  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  rdy = 1'b1;
  logic                  clear = 1'b0;
  logic                  issue_valid = 1'b0;
  logic [3:0]            issue_op = '0;
  logic [31:0]           issue_vj = '0, issue_vk = '0, issue_imm = '0;
  logic                  issue_dj = 1'b0, issue_dk = 1'b0;
  logic [ROB_W-1:0]      issue_qj = '0, issue_qk = '0, issue_rob_id = '0;
  logic                  full;
  logic [NCDB-1:0]       cdb_valid = '0;
  logic [NCDB*ROB_W-1:0] cdb_rob_id = '0;
  logic [NCDB*32-1:0]    cdb_value = '0;
  logic                  commit_store = 1'b0;
  logic                  mem_req;
  logic [31:0]           mem_addr, mem_wdata;
  logic [3:0]            mem_op;
  logic                  mem_done = 1'b0;
  logic [31:0]           mem_rdata = '0;
  logic                  out_valid;
  logic [ROB_W-1:0]      out_rob_id;
  logic [31:0]           out_value;

  int checks = 0;
  int errors = 0;

  lsb_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NCDB(NCDB)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj),
    .issue_vk(issue_vk), .issue_imm(issue_imm), .issue_dj(issue_dj),
    .issue_dk(issue_dk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_rob_id(issue_rob_id), .full(full), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .commit_store(commit_store),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_op(mem_op),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_rob_id(out_rob_id), .out_value(out_value)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      vj, vk, imm, rdata;
    logic [ROB_W-1:0] tag;
    logic [31:0]      exp_addr, exp_wdata, exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic dj, input logic dk,
                       input logic [ROB_W-1:0] qj, input logic [ROB_W-1:0] qk,
                       input logic [ROB_W-1:0] tag);
    issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk; issue_imm = imm;
    issue_dj = dj; issue_dk = dk; issue_qj = qj; issue_qk = qk; issue_rob_id = tag;
    step();
    issue_valid = 1'b0; issue_dj = 1'b0; issue_dk = 1'b0;
  endtask

  task automatic done(input logic [31:0] rd);
    mem_done = 1'b1; mem_rdata = rd;
    step();
    mem_done = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 40) begin
      step();
      n++;
    end
    chk(name, {31'b0, mem_req}, 32'h1);
  endtask

  task automatic commit();
    commit_store = 1'b1;
    step();
    commit_store = 1'b0;
  endtask

  initial begin
    logic seen;
    vecs[0] = '{OP_LW,  32'h100,      32'h0,        32'h4,        32'hDEAD,     4'd1, 32'h104,  32'h0,        32'hDEAD};
    vecs[1] = '{OP_LB,  32'h2000,     32'hFFFF0000, 32'hFFFFFFFF, 32'h7F,       4'd2, 32'h1FFF, 32'h0,        32'h7F};
    vecs[2] = '{OP_SW,  32'h40,       32'hCAFEBABE, 32'h10,       32'h1111,     4'd5, 32'h50,   32'hCAFEBABE, 32'h0};
    vecs[3] = '{OP_LHU, 32'hFFFFFFFC, 32'h0,        32'h8,        32'h1234,     4'd7, 32'h4,    32'h0,        32'h1234};
    vecs[4] = '{OP_SB,  32'h0,        32'hA5,       32'h80,       32'h2222,     4'hF, 32'h80,   32'hA5,       32'h0};
    vecs[5] = '{OP_LW,  32'h12345678, 32'h0,        32'h0,        32'hFFFFFFFF, 4'd9, 32'h12345678, 32'h0,    32'hFFFFFFFF};

    step(); step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_count", 32'(dut.count_q), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // Single load: exact request and broadcast latency.
    issue(OP_LW, 32'h100, 32'h0, 32'h4, 1'b0, 1'b0, '0, '0, 4'd1);
    chk("lw_req_early", {31'b0, mem_req}, 32'h0);
    step();
    chk("lw_req", {31'b0, mem_req}, 32'h1);
    chk("lw_addr", mem_addr, 32'h104);
    done(32'hDEAD);
    chk("lw_req_drop", {31'b0, mem_req}, 32'h0);
    chk("lw_out_valid", {31'b0, out_valid}, 32'h1);
    chk("lw_out_value", out_value, 32'hDEAD);
    step();
    chk("lw_out_pulse", {31'b0, out_valid}, 32'h0);

    // Table of independent loads and committed stores.
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].op, vecs[v].vj, vecs[v].vk, vecs[v].imm, 1'b0, 1'b0, '0, '0, vecs[v].tag);
      if (vecs[v].op[3]) commit();
      wait_req($sformatf("vec%0d_req", v));
      chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].exp_addr);
      chk($sformatf("vec%0d_wdata", v), mem_wdata, vecs[v].exp_wdata);
      chk($sformatf("vec%0d_op", v), {28'b0, mem_op}, {28'b0, vecs[v].op});
      done(vecs[v].rdata);
      chk($sformatf("vec%0d_out_valid", v), {31'b0, out_valid}, 32'h1);
      chk($sformatf("vec%0d_rob", v), {28'b0, out_rob_id}, {28'b0, vecs[v].tag});
      chk($sformatf("vec%0d_value", v), out_value, vecs[v].exp_out);
    end

    // Store waits on tag 3 from port 1, then needs commit.
    issue(OP_SW, 32'h300, 32'h0, 32'h0, 1'b0, 1'b1, '0, 4'd3, 4'd4);
    cdb_valid = 2'b11; cdb_rob_id = {4'd3, 4'd6}; cdb_value = {32'h55, 32'h99};
    step();
    cdb_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req) seen = 1'b1;
    end
    chk("sw_no_commit_req", {31'b0, seen}, 32'h0);
    commit();
    wait_req("sw_req");
    chk("sw_wdata", mem_wdata, 32'h55);
    chk("sw_addr", mem_addr, 32'h300);
    done(32'h0);
    chk("sw_out_valid", {31'b0, out_valid}, 32'h1);
    chk("sw_out_rob", {28'b0, out_rob_id}, 32'h4);
    chk("sw_out_value", out_value, 32'h0);

    // Same-cycle bypass with both ports matching: port 0 wins.
    cdb_valid = 2'b11; cdb_rob_id = {4'd2, 4'd2}; cdb_value = {32'h2000, 32'h1000};
    issue(OP_LW, 32'h0, 32'h0, 32'h8, 1'b1, 1'b0, 4'd2, '0, 4'd6);
    cdb_valid = '0;
    step();
    chk("byp_req", {31'b0, mem_req}, 32'h1);
    chk("byp_addr", mem_addr, 32'h1008);
    done(32'h66);
    chk("byp_out_value", out_value, 32'h66);

    // Fill to DEPTH, overflow, pop with issue, wrap.
    for (int i = 0; i < DEPTH; i++)
      issue(OP_LW, 32'(i * 16), 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, ROB_W'(i));
    chk("fill_full", {31'b0, full}, 32'h1);
    chk("fill_count", 32'(dut.count_q), 32'd16);
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'hD);
    chk("overflow_count", 32'(dut.count_q), 32'd16);
    done(32'h0);
    chk("pop0_rob", {28'b0, out_rob_id}, 32'h0);
    chk("pop0_count", 32'(dut.count_q), 32'd15);
    chk("pop0_full", {31'b0, full}, 32'h0);
    wait_req("pop1_req");
    issue_valid = 1'b1; issue_op = OP_LW; issue_vj = 32'h0; issue_imm = 32'h0; issue_rob_id = 4'hA;
    mem_done = 1'b1;
    step();
    issue_valid = 1'b0; mem_done = 1'b0;
    chk("pop_issue_rob", {28'b0, out_rob_id}, 32'h1);
    chk("pop_issue_count", 32'(dut.count_q), 32'd15);
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'hB);
    chk("refill_count", 32'(dut.count_q), 32'd16);
    chk("refill_full", {31'b0, full}, 32'h1);
    for (int i = 2; i < 18; i++) begin
      logic [ROB_W-1:0] exp_tag;
      exp_tag = (i < 16) ? ROB_W'(i) : ((i == 16) ? 4'hA : 4'hB);
      wait_req($sformatf("drain%0d_req", i));
      done(32'h0);
      chk($sformatf("drain%0d_rob", i), {28'b0, out_rob_id}, {28'b0, exp_tag});
    end
    chk("drain_count", 32'(dut.count_q), 32'd0);

    // Flush with a committed but blocked store at head; issue in clear cycle ignored.
    issue(OP_SW, 32'h500, 32'h0, 32'h0, 1'b0, 1'b1, '0, 4'd7, 4'd3);
    commit();
    for (int i = 0; i < 3; i++)
      issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, ROB_W'(8 + i));
    chk("clra_count_pre", 32'(dut.count_q), 32'd4);
    clear = 1'b1;
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd11);
    clear = 1'b0;
    chk("clra_count", 32'(dut.count_q), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_req || out_valid) seen = 1'b1;
    end
    chk("clra_quiet", {31'b0, seen}, 32'h0);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd7}; cdb_value = {32'h0, 32'h77};
    step();
    cdb_valid = '0;
    wait_req("clra_req");
    chk("clra_wdata", mem_wdata, 32'h77);
    done(32'h0);
    chk("clra_out_rob", {28'b0, out_rob_id}, 32'h3);
    chk("clra_out_valid", {31'b0, out_valid}, 32'h1);
    chk("clra_count_end", 32'(dut.count_q), 32'd0);

    // Flush while a load is in flight: no broadcast for it.
    for (int i = 1; i < 4; i++)
      issue(OP_LW, 32'h600, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, ROB_W'(i));
    chk("clrb_req", {31'b0, mem_req}, 32'h1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clrb_count", 32'(dut.count_q), 32'd0);
    step(); step();
    chk("clrb_hold", {31'b0, mem_req}, 32'h1);
    done(32'hBAD);
    chk("clrb_no_out", {31'b0, out_valid}, 32'h0);
    chk("clrb_req_drop", {31'b0, mem_req}, 32'h0);
    step(); step();
    chk("clrb_no_relaunch", {31'b0, mem_req}, 32'h0);
    issue(OP_LW, 32'h700, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd4);
    wait_req("clrb_next_req");
    chk("clrb_next_addr", mem_addr, 32'h700);
    done(32'h44);
    chk("clrb_next_value", out_value, 32'h44);
    chk("clrb_next_rob", {28'b0, out_rob_id}, 32'h4);

    // Flush while a committed store is in flight: it completes.
    issue(OP_SW, 32'h800, 32'h88, 32'h0, 1'b0, 1'b0, '0, '0, 4'd5);
    commit();
    wait_req("clrc_req");
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd6);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clrc_count", 32'(dut.count_q), 32'd1);
    done(32'h0);
    chk("clrc_out_valid", {31'b0, out_valid}, 32'h1);
    chk("clrc_out_rob", {28'b0, out_rob_id}, 32'h5);
    chk("clrc_count_end", 32'(dut.count_q), 32'd0);

    // Asynchronous reset in the middle of a transaction.
    issue(OP_LW, 32'h900, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd2);
    issue(OP_LW, 32'h904, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd3);
    wait_req("rst_busy_req");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("arst_count", 32'(dut.count_q), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req || out_valid) seen = 1'b1;
      step();
    end
    chk("arst_quiet", {31'b0, seen}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
